dram_axi_bridge: RTL and testbench
==================================

DRAM_AXI_BRIDGE -- requirements
Module: dram_axi_bridge

Interface
REQ-001 The module SHALL have parameter AXI_ID, default 4'd1: constant value driven on arid and awid.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port dram_en, input, 1 bit: processor data request valid.
REQ-005 The module SHALL have port dram_wen, input, 4 bits: byte write enables; 0000 = read.
REQ-006 The module SHALL have port dram_addr, input, 32 bits: byte address.
REQ-007 The module SHALL have port dram_wdata, input, 32 bits: store data.
REQ-008 The module SHALL have port dram_rdata, output, 32 bits: load data.
REQ-009 The module SHALL have port dram_wait, output, 1 bit: request not yet complete; processor holds its request stable.
REQ-010 The module SHALL have port bus_err, output, 1 bit: one-cycle pulse for an errored response.
REQ-011 The module SHALL have AXI read ports: arid[3:0], araddr[31:0], arsize[2:0], arvalid and rready (outputs); arready, rdata[31:0], rresp[1:0] and rvalid (inputs).
REQ-012 The module SHALL have AXI write ports: awid[3:0], awaddr[31:0], awsize[2:0], awvalid, wdata[31:0], wstrb[3:0], wvalid and bready (outputs); awready, wready, bresp[1:0] and bvalid (inputs).

Function
REQ-013 The FSM SHALL have states IDLE, RADDR, RDATA, WREQ, WRESP and DONE.
REQ-014 In IDLE with dram_en=1, the block SHALL latch addr, wen and wdata, then go to RADDR if wen==0, else to WREQ.
REQ-015 dram_wait SHALL be a combinational signal: 1 when dram_en=1 and state!=DONE, 0 otherwise (including IDLE with dram_en=0).
REQ-016 In RADDR the block SHALL assert arvalid with araddr = latched addr and arsize = 3'b010.
- arvalid SHALL stay high until arready is sampled high.
- Then the state SHALL go to RDATA.
REQ-017 In RDATA the block SHALL assert rready.
- On rvalid, it SHALL capture rdata and rresp and go to DONE.
REQ-018 In WREQ the block SHALL assert awvalid and wvalid, with awaddr = addr, awsize = 3'b010, wstrb = latched wen and wdata = latched wdata.
- Each valid SHALL drop independently after its own ready is sampled.
- The AW and W handshakes MAY complete in the same cycle or in either order.
- The block SHALL go to WRESP only after both handshakes have completed.
REQ-019 In WRESP the block SHALL assert bready.
- On bvalid, it SHALL capture bresp and go to DONE.
REQ-020 DONE SHALL last exactly one cycle, then return to IDLE.
- In DONE, dram_wait SHALL be 0.
- dram_rdata SHALL hold the captured read data; it SHALL hold its last value otherwise.
- bus_err SHALL be 1 if the captured resp[1]==1 (SLVERR/DECERR) and 0 otherwise.
REQ-021 A dram_en=1 seen in the cycle after DONE SHALL be treated as a new request; it is never a re-issue.
REQ-022 Minimum latency SHALL be 3 cycles from request to the dram_wait=0 cycle, with arready/rvalid high immediately.
REQ-023 A write SHALL have the same minimum latency as a read (3 cycles).
REQ-024 The block SHALL have at most one outstanding transaction; no AXI valid SHALL be asserted in IDLE or DONE.
REQ-025 The block SHALL ignore a change of dram_en/dram_addr while busy; the latched values govern the transaction.

Reset
REQ-026 When rst=0, the block SHALL immediately (asynchronously) force state to IDLE.
REQ-027 When rst=0, the block SHALL force all AXI valid/ready outputs, bus_err and dram_rdata to 0.
REQ-028 When rst=0, the block SHALL force the latched registers to 0.
REQ-029 Reset mid-transaction SHALL abandon the transaction; no response SHALL be expected afterward.

Verification
REQ-030 Read with zero-wait slave: en=1, wen=0000, addr=0x1FC00010, slave rdata=0xDEADBEEF.
- Required: arvalid in cycle 1, rready in cycle 2, dram_wait=0 and dram_rdata=0xDEADBEEF in cycle 3.
REQ-031 Write with awready delayed 3 cycles and wready immediate: wen=0011, wdata=0x12345678.
- Required: wvalid drops after 1 cycle, awvalid is held 4 cycles, and wstrb=0011.
- Required: DONE occurs only after bvalid.
REQ-032 Read with rresp=2'b10.
- Required: bus_err=1 for exactly the DONE cycle, and dram_wait=0 in that cycle.
REQ-033 Back-to-back requests: read then write with dram_en held 1 across DONE.
- Required: the second transaction starts from IDLE the cycle after DONE, with no duplicate AR.
REQ-034 rst pulled to 0 while in RDATA with rvalid never asserted.
- Required: rready=0 immediately and state=IDLE.
- Required: after release, a new read completes normally.

Source files
------------

// File: rtl/dram_axi_bridge.sv
// Bridges a single-request processor data port onto AXI4-Lite style read and write channels.
// One transaction is in flight at a time; request fields are latched on acceptance.
module dram_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dram_en,
  input  logic [3:0]  dram_wen,
  input  logic [31:0] dram_addr,
  input  logic [31:0] dram_wdata,
  output logic [31:0] dram_rdata,
  output logic        dram_wait,
  output logic        bus_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_t;

  state_t      state_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic [3:0]  wen_reg;
  logic [1:0]  resp_reg;
  logic        aw_done_reg;
  logic        w_done_reg;

  logic aw_hs;
  logic w_hs;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
      wen_reg     <= '0;
      resp_reg    <= '0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (dram_en) begin
            addr_reg  <= dram_addr;
            wen_reg   <= dram_wen;
            wdata_reg <= dram_wdata;
            state_reg <= (dram_wen == 4'b0000) ? RADDR : WREQ;
          end
        end
        RADDR: begin
          if (arready) state_reg <= RDATA;
        end
        RDATA: begin
          if (rvalid) begin
            rdata_reg <= rdata;
            resp_reg  <= rresp;
            state_reg <= DONE;
          end
        end
        WREQ: begin
          // AW and W retire independently; leave only once both have been accepted.
          if (aw_hs) aw_done_reg <= 1'b1;
          if (w_hs)  w_done_reg  <= 1'b1;
          if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            state_reg   <= WRESP;
          end
        end
        WRESP: begin
          if (bvalid) begin
            resp_reg  <= bresp;
            state_reg <= DONE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Channel controls decode straight from the state register, so reset clears them at once.
  assign arvalid    = (state_reg == RADDR);
  assign rready     = (state_reg == RDATA);
  assign awvalid    = (state_reg == WREQ) && !aw_done_reg;
  assign wvalid     = (state_reg == WREQ) && !w_done_reg;
  assign bready     = (state_reg == WRESP);
  assign arid       = AXI_ID;
  assign awid       = AXI_ID;
  assign araddr     = addr_reg;
  assign awaddr     = addr_reg;
  assign arsize     = 3'b010;
  assign awsize     = 3'b010;
  assign wdata      = wdata_reg;
  assign wstrb      = wen_reg;
  assign dram_rdata = rdata_reg;
  assign bus_err    = (state_reg == DONE) && resp_reg[1];
  assign dram_wait  = dram_en && (state_reg != DONE);

endmodule

// File: tb/tb_dram_axi_bridge.sv
// Self-checking bench for dram_axi_bridge: vector table run against a delay-programmable AXI slave,
// with a scoreboard queue of expected completions plus back-to-back and mid-transaction reset sequences.
module tb_dram_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        dram_en;
  logic [3:0]  dram_wen;
  logic [31:0] dram_addr, dram_wdata, dram_rdata;
  logic        dram_wait, bus_err;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  dram_axi_bridge #(.AXI_ID(4'd1)) dut (
    .clk(clk), .rst(rst), .dram_en(dram_en), .dram_wen(dram_wen), .dram_addr(dram_addr),
    .dram_wdata(dram_wdata), .dram_rdata(dram_rdata), .dram_wait(dram_wait), .bus_err(bus_err),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Slave: each ready/valid answers after a programmable number of waiting cycles.
  int          ar_d, r_d, aw_d, w_d, b_d;
  int          ar_w, r_w, aw_w, w_w, b_w;
  int          ar_cnt, aw_cnt, w_cnt;
  logic [31:0] s_rdata;
  logic [1:0]  s_resp;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb, cap_arid, cap_awid;
  logic [2:0]  cap_arsize, cap_awsize;

  assign arready = arvalid && (ar_w >= ar_d);
  assign rvalid  = rready  && (r_w  >= r_d);
  assign awready = awvalid && (aw_w >= aw_d);
  assign wready  = wvalid  && (w_w  >= w_d);
  assign bvalid  = bready  && (b_w  >= b_d);
  assign rdata   = s_rdata;
  assign rresp   = s_resp;
  assign bresp   = s_resp;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ar_w <= 0; r_w <= 0; aw_w <= 0; w_w <= 0; b_w <= 0;
      ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0;
      cap_araddr <= '0; cap_awaddr <= '0; cap_wdata <= '0; cap_wstrb <= '0;
      cap_arid <= '0; cap_awid <= '0; cap_arsize <= '0; cap_awsize <= '0;
    end else begin
      ar_w <= (arvalid && !arready) ? ar_w + 1 : 0;
      r_w  <= (rready  && !rvalid)  ? r_w  + 1 : 0;
      aw_w <= (awvalid && !awready) ? aw_w + 1 : 0;
      w_w  <= (wvalid  && !wready)  ? w_w  + 1 : 0;
      b_w  <= (bready  && !bvalid)  ? b_w  + 1 : 0;
      if (arvalid && arready) begin
        ar_cnt <= ar_cnt + 1; cap_araddr <= araddr; cap_arid <= arid; cap_arsize <= arsize;
      end
      if (awvalid && awready) begin
        aw_cnt <= aw_cnt + 1; cap_awaddr <= awaddr; cap_awid <= awid; cap_awsize <= awsize;
      end
      if (wvalid && wready) begin
        w_cnt <= w_cnt + 1; cap_wdata <= wdata; cap_wstrb <= wstrb;
      end
    end
  end

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic [1:0]  resp;
    int          ar_d, r_d, aw_d, w_d, b_d;
    int          lat;
    bit          err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   txn_no = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drives one request from a negedge and follows it to its dram_wait=0 cycle.
  // extra = idle cycles expected before acceptance; keep_en leaves dram_en high across DONE.
  task automatic run_vec(input vec_t v, input bit keep_en, input int extra);
    int cyc, errc, avc, wvc, ar0, aw0, w0;
    bit done;
    vec_t e;
    ar_d = v.ar_d; r_d = v.r_d; aw_d = v.aw_d; w_d = v.w_d; b_d = v.b_d;
    s_rdata = v.rdat; s_resp = v.resp;
    dram_en = 1'b1;
    dram_wen = v.is_wr ? v.wen : 4'b0000;
    dram_addr = v.addr;
    dram_wdata = v.wdat;
    sb.push_back(v);
    ar0 = ar_cnt; aw0 = aw_cnt; w0 = w_cnt;
    cyc = 0; errc = 0; avc = 0; wvc = 0; done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus_err) errc++;
      if (awvalid) avc++;
      if (wvalid) wvc++;
      // Once latched, the request lines are scrambled; the latched copy must still govern.
      if (cyc == 1 + extra) begin
        dram_addr = ~v.addr;
        dram_wdata = ~v.wdat;
      end
      if (!dram_wait) done = 1'b1;
    end
    chk("completion_seen", {31'd0, done}, 32'd1);
    e = sb.pop_front();
    chk("latency", cyc, e.lat + extra);
    chk("dram_rdata", dram_rdata, e.exp_rdata);
    chk("bus_err_cycles", errc, {31'd0, e.err});
    if (!e.is_wr) begin
      chk("ar_count", ar_cnt - ar0, 1);
      chk("aw_count_rd", aw_cnt - aw0, 0);
      chk("araddr", cap_araddr, e.addr);
      chk("arsize", {29'd0, cap_arsize}, 32'd2);
      chk("arid", {28'd0, cap_arid}, 32'd1);
    end else begin
      chk("aw_count", aw_cnt - aw0, 1);
      chk("w_count", w_cnt - w0, 1);
      chk("ar_count_wr", ar_cnt - ar0, 0);
      chk("awaddr", cap_awaddr, e.addr);
      chk("wdata", cap_wdata, e.wdat);
      chk("wstrb", {28'd0, cap_wstrb}, {28'd0, e.wen});
      chk("awsize", {29'd0, cap_awsize}, 32'd2);
      chk("awid", {28'd0, cap_awid}, 32'd1);
      chk("awvalid_cycles", avc, e.aw_d + 1);
      chk("wvalid_cycles", wvc, e.w_d + 1);
    end
    $display("TXN %0d %s addr=%h lat=%0d rdata=%h err_cycles=%0d", txn_no, e.is_wr ? "WR" : "RD",
             e.addr, cyc, dram_rdata, errc);
    txn_no++;
    if (!keep_en) begin
      dram_en = 1'b0;
      @(negedge clk);
      chk("bus_err_after_done", {31'd0, bus_err}, 32'd0);
      chk("idle_no_valid", {29'd0, arvalid, awvalid, wvalid}, 32'd0);
    end
  endtask

  initial begin
    vec_t v;
    int   n;
    //          wr addr          wen   wdata          rdata          resp   ar r aw w b lat err exp_rdata
    vecs[0] = '{0, 32'h1FC00010, 4'h0, 32'h00000000, 32'hDEADBEEF, 2'b00, 0, 0, 0, 0, 0, 3, 0, 32'hDEADBEEF};
    vecs[1] = '{1, 32'h00001000, 4'h3, 32'h12345678, 32'h00000000, 2'b00, 0, 0, 3, 0, 1, 7, 0, 32'hDEADBEEF};
    vecs[2] = '{0, 32'h00000020, 4'h0, 32'h00000000, 32'hCAFEF00D, 2'b10, 1, 2, 0, 0, 0, 6, 1, 32'hCAFEF00D};
    vecs[3] = '{1, 32'h00000040, 4'hF, 32'h0F0F0F0F, 32'h00000000, 2'b11, 0, 0, 0, 2, 0, 5, 1, 32'hCAFEF00D};
    vecs[4] = '{1, 32'h00000044, 4'h8, 32'hAABBCCDD, 32'h00000000, 2'b00, 0, 0, 0, 0, 0, 3, 0, 32'hCAFEF00D};
    vecs[5] = '{0, 32'h00000048, 4'h0, 32'h00000000, 32'h0BADC0DE, 2'b01, 0, 0, 0, 0, 0, 3, 0, 32'h0BADC0DE};

    rst = 1'b0; dram_en = 1'b0; dram_wen = '0; dram_addr = '0; dram_wdata = '0;
    ar_d = 0; r_d = 0; aw_d = 0; w_d = 0; b_d = 0; s_rdata = '0; s_resp = '0;
    repeat (3) @(negedge clk);
    chk("reset_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
    chk("reset_rdata", dram_rdata, 32'd0);
    chk("reset_bus_err", {31'd0, bus_err}, 32'd0);
    chk("reset_wait_idle", {31'd0, dram_wait}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b0, 0);

    // Read then write with dram_en held high through DONE.
    v = '{0, 32'h1FC00020, 4'h0, 32'h00000000, 32'h11112222, 2'b00, 0, 0, 0, 0, 0, 3, 0, 32'h11112222};
    run_vec(v, 1'b1, 0);
    v = '{1, 32'h00000030, 4'h4, 32'hA5A5A5A5, 32'h00000000, 2'b00, 0, 0, 0, 0, 0, 3, 0, 32'h11112222};
    run_vec(v, 1'b0, 1);

    // Reset while waiting in RDATA for a response that never comes.
    r_d = 1000; ar_d = 0; s_rdata = 32'h99999999; s_resp = 2'b00;
    dram_en = 1'b1; dram_wen = 4'b0000; dram_addr = 32'h00000060;
    n = 0;
    while (!rready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reached_rdata", {31'd0, rready}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_rready_now", {31'd0, rready}, 32'd0);
    chk("rst_valids_now", {28'd0, arvalid, awvalid, wvalid, bready}, 32'd0);
    chk("rst_rdata_now", dram_rdata, 32'd0);
    dram_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {30'd0, arvalid, rready}, 32'd0);
    v = '{0, 32'h00000050, 4'h0, 32'h00000000, 32'h77778888, 2'b00, 0, 0, 0, 0, 0, 3, 0, 32'h77778888};
    run_vec(v, 1'b0, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
